// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcode/funct
// constants, ALU operation codes (also used by the ALU) and mux select codes.
package multi_cycle_control_pkg;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IXEC   = 4'd11,
        S_IWB    = 4'd12,
        S_JAL    = 4'd13
    } state_t;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SLL = 4'd3,
        ALU_SRL = 4'd4,
        ALU_LUI = 4'd5,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd8,
        ALU_XOR = 4'd9
    } alu_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] SRCA_PC   = 2'd0;
    localparam logic [1:0] SRCA_REGA = 2'd1;
    localparam logic [1:0] SRCA_REGB = 2'd2;
    localparam logic [1:0] SRCB_REGB = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_IMM2 = 2'd3;
    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;

    function automatic logic is_itype(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
               (op == OP_XORI) || (op == OP_SLTI) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Controller <-> datapath signal bundle. master = controller, slave = datapath.
interface multi_cycle_control_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       Zero;
    logic       PCEn;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ExtOp;
    logic       IllegalOp;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [3:0] ALUcontrol;
    logic [3:0] state;

    modport master (
        input  op, funct, Zero,
        output PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ExtOp, IllegalOp, ALUSrcA, ALUSrcB, PCSource,
               ALUcontrol, state
    );

    modport slave (
        output op, funct, Zero,
        input  PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ExtOp, IllegalOp, ALUSrcA, ALUSrcB, PCSource,
               ALUcontrol, state
    );
endinterface

// File: rtl/multi_cycle_control_alu_decode.sv
// Combinational ALU operation decode: funct for R-type, op for I-type.
import multi_cycle_control_pkg::*;

module alu_decode (
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output alu_t       r_alu,
    output logic       r_shift,
    output logic       r_valid,
    output alu_t       i_alu,
    output logic       i_ext
);
    always_comb begin
        r_alu   = ALU_ADD;
        r_shift = 1'b0;
        r_valid = 1'b1;
        case (funct)
            FN_ADD: r_alu = ALU_ADD;
            FN_SUB: r_alu = ALU_SUB;
            FN_AND: r_alu = ALU_AND;
            FN_OR:  r_alu = ALU_OR;
            FN_XOR: r_alu = ALU_XOR;
            FN_NOR: r_alu = ALU_NOR;
            FN_SLT: r_alu = ALU_SLT;
            FN_SLL: begin r_alu = ALU_SLL; r_shift = 1'b1; end
            FN_SRL: begin r_alu = ALU_SRL; r_shift = 1'b1; end
            default: r_valid = 1'b0;
        endcase
    end

    // Logical immediates are zero-extended; arithmetic ones sign-extended.
    always_comb begin
        i_alu = ALU_ADD;
        i_ext = 1'b1;
        case (op)
            OP_ADDI: begin i_alu = ALU_ADD; i_ext = 1'b1; end
            OP_ANDI: begin i_alu = ALU_AND; i_ext = 1'b0; end
            OP_ORI:  begin i_alu = ALU_OR;  i_ext = 1'b0; end
            OP_XORI: begin i_alu = ALU_XOR; i_ext = 1'b0; end
            OP_SLTI: begin i_alu = ALU_SLT; i_ext = 1'b1; end
            OP_LUI:  begin i_alu = ALU_LUI; i_ext = 1'b0; end
            default: begin i_alu = ALU_ADD; i_ext = 1'b1; end
        endcase
    end
endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style control FSM with registered outputs.
// Optional feature: define MC_CTRL_JAL_EN to add the JAL (op 0x03) state.
//
// state  | meaning
// INIT   | post-reset idle, all outputs 0
// FETCH  | read instruction, PC <= PC+4
// DECODE | branch target into ALUOut, dispatch on op
// MEMADR | address = regA + ext imm
// MEMRD  | data memory read
// MEMWB  | load writeback (rt)
// MEMWR  | data memory write
// RXEC   | R-type execute
// RWB    | R-type writeback (rd)
// BRANCH | beq/bne compare, conditional PC update
// JUMP   | PC <= jump target
// IXEC   | I-type execute
// IWB    | I-type writeback (rt)
// JAL    | jump and link to r31 (optional)
import multi_cycle_control_pkg::*;

module multi_cycle_control (
    input  logic                        clk,
    input  logic                        rst_n,
    multi_cycle_control_if.master       bus
);
    state_t     cur, nxt;
    logic       ill_nxt, ill_q;
    logic       pcen_q, iord_q, memread_q, memwrite_q, irwrite_q;
    logic       memtoreg_q, regdst_q, regwrite_q, ext_q;
    logic [1:0] srca_q, srcb_q, pcsrc_q;
    alu_t       alu_q;

    alu_t       r_alu, i_alu;
    logic       r_shift, r_valid, i_ext;

    alu_decode u_alu_decode (
        .op      (bus.op),
        .funct   (bus.funct),
        .r_alu   (r_alu),
        .r_shift (r_shift),
        .r_valid (r_valid),
        .i_alu   (i_alu),
        .i_ext   (i_ext)
    );

    always_comb begin
        nxt     = S_FETCH;
        ill_nxt = 1'b0;
        case (cur)
            S_INIT:   nxt = S_FETCH;
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                if (bus.op == OP_LW || bus.op == OP_SW)        nxt = S_MEMADR;
                else if (bus.op == OP_RTYPE)                   nxt = S_RXEC;
                else if (bus.op == OP_BEQ || bus.op == OP_BNE) nxt = S_BRANCH;
                else if (bus.op == OP_J)                       nxt = S_JUMP;
                else if (is_itype(bus.op))                     nxt = S_IXEC;
`ifdef MC_CTRL_JAL_EN
                else if (bus.op == OP_JAL)                     nxt = S_JAL;
`endif
                else                                           ill_nxt = 1'b1;
            end
            S_MEMADR: nxt = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nxt = S_MEMWB;
            S_RXEC: begin
                nxt     = r_valid ? S_RWB : S_FETCH;
                ill_nxt = ~r_valid;
            end
            S_IXEC:   nxt = S_IWB;
            default:  nxt = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state so they are valid for the
    // whole cycle spent in that state; IllegalOp is raised for the cycle
    // following the rejecting DECODE/RXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= S_INIT;
            ill_q      <= 1'b0;
            pcen_q     <= 1'b0;
            iord_q     <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            irwrite_q  <= 1'b0;
            memtoreg_q <= 1'b0;
            regdst_q   <= 1'b0;
            regwrite_q <= 1'b0;
            ext_q      <= 1'b0;
            srca_q     <= 2'd0;
            srcb_q     <= 2'd0;
            pcsrc_q    <= 2'd0;
            alu_q      <= ALU_AND;
        end else begin
            cur        <= nxt;
            ill_q      <= ill_nxt;
            pcen_q     <= 1'b0;
            iord_q     <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            irwrite_q  <= 1'b0;
            memtoreg_q <= 1'b0;
            regdst_q   <= 1'b0;
            regwrite_q <= 1'b0;
            ext_q      <= 1'b0;
            srca_q     <= SRCA_PC;
            srcb_q     <= SRCB_REGB;
            pcsrc_q    <= PCS_ALU;
            alu_q      <= ALU_AND;
            case (nxt)
                S_FETCH: begin
                    memread_q <= 1'b1;
                    irwrite_q <= 1'b1;
                    pcen_q    <= 1'b1;
                    srcb_q    <= SRCB_FOUR;
                    alu_q     <= ALU_ADD;
                end
                S_DECODE: begin
                    srcb_q <= SRCB_IMM2;
                    ext_q  <= 1'b1;
                    alu_q  <= ALU_ADD;
                end
                S_MEMADR: begin
                    srca_q <= SRCA_REGA;
                    srcb_q <= SRCB_IMM;
                    ext_q  <= 1'b1;
                    alu_q  <= ALU_ADD;
                end
                S_MEMRD: begin
                    memread_q <= 1'b1;
                    iord_q    <= 1'b1;
                end
                S_MEMWB: begin
                    regwrite_q <= 1'b1;
                    memtoreg_q <= 1'b1;
                end
                S_MEMWR: begin
                    memwrite_q <= 1'b1;
                    iord_q     <= 1'b1;
                end
                S_RXEC: begin
                    srca_q <= r_shift ? SRCA_REGB : SRCA_REGA;
                    srcb_q <= r_shift ? SRCB_IMM : SRCB_REGB;
                    alu_q  <= r_alu;
                end
                S_RWB: begin
                    regwrite_q <= 1'b1;
                    regdst_q   <= 1'b1;
                end
                S_BRANCH: begin
                    srca_q  <= SRCA_REGA;
                    srcb_q  <= SRCB_REGB;
                    alu_q   <= ALU_SUB;
                    pcsrc_q <= PCS_ALUOUT;
                end
                S_JUMP: begin
                    pcsrc_q <= PCS_JUMP;
                    pcen_q  <= 1'b1;
                end
                S_IXEC: begin
                    srca_q <= SRCA_REGA;
                    srcb_q <= SRCB_IMM;
                    alu_q  <= i_alu;
                    ext_q  <= i_ext;
                end
                S_IWB: begin
                    regwrite_q <= 1'b1;
                    srca_q     <= srca_q;
                    srcb_q     <= srcb_q;
                    alu_q      <= alu_q;
                    ext_q      <= ext_q;
                end
                S_JAL: begin
                    pcsrc_q    <= PCS_JUMP;
                    pcen_q     <= 1'b1;
                    regwrite_q <= 1'b1;
                    regdst_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // PCEn is the only output that looks at Zero directly.
    assign bus.PCEn       = (cur == S_BRANCH) ? ((bus.op == OP_BNE) ? ~bus.Zero : bus.Zero)
                                              : pcen_q;
    assign bus.IorD       = iord_q;
    assign bus.MemRead    = memread_q;
    assign bus.MemWrite   = memwrite_q;
    assign bus.IRWrite    = irwrite_q;
    assign bus.MemtoReg   = memtoreg_q;
    assign bus.RegDst     = regdst_q;
    assign bus.RegWrite   = regwrite_q;
    assign bus.ExtOp      = ext_q;
    assign bus.IllegalOp  = ill_q;
    assign bus.ALUSrcA    = srca_q;
    assign bus.ALUSrcB    = srcb_q;
    assign bus.PCSource   = pcsrc_q;
    assign bus.ALUcontrol = alu_q;
    assign bus.state      = cur;
endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed per-cycle vector bench for multi_cycle_control; honours
// MC_CTRL_JAL_EN to choose the expected op 0x03 behaviour.
module tb_multi_cycle_control;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_cycle_control_if bus();
    multi_cycle_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [3:0]  st;
        logic [19:0] ctrl;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    // {PCEn,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ExtOp,IllegalOp,
    //  ALUSrcA,ALUSrcB,PCSource,ALUcontrol}
    function automatic logic [19:0] ctl(input bit pcen, iord, mr, mw, irw, m2r, rd, rw, ext, ill,
                                        input logic [1:0] sa, sb, ps, input logic [3:0] alu);
        return {pcen, iord, mr, mw, irw, m2r, rd, rw, ext, ill, sa, sb, ps, alu};
    endfunction

    function automatic logic [19:0] act_ctrl();
        return {bus.PCEn, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg,
                bus.RegDst, bus.RegWrite, bus.ExtOp, bus.IllegalOp,
                bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALUcontrol};
    endfunction

    task automatic check(input string name, input logic [3:0] est, input logic [19:0] ectl);
        n_vec++;
        if (bus.state !== est || act_ctrl() !== ectl) begin
            n_err++;
            $display("FAIL %s: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                     name, bus.state, act_ctrl(), est, ectl);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic [3:0] st, input logic [19:0] c, input string name);
        vec_t v;
        v.op = op; v.funct = fn; v.zero = z; v.st = st; v.ctrl = c; v.name = name;
        vecs.push_back(v);
    endtask

    logic [19:0] F, FI, D, MA, MRD, MWB, MWR, RWB, JMP;

    function automatic logic [19:0] rx(input logic [3:0] alu, input bit sh);
        return ctl(0,0,0,0,0,0,0,0,0,0, sh ? 2'd2 : 2'd1, sh ? 2'd2 : 2'd0, 2'd0, alu);
    endfunction
    function automatic logic [19:0] br(input bit pcen);
        return ctl(pcen,0,0,0,0,0,0,0,0,0, 2'd1, 2'd0, 2'd1, 4'd6);
    endfunction
    function automatic logic [19:0] ix(input logic [3:0] alu, input bit ext, input bit wb);
        return ctl(0,0,0,0,0,0,0,wb,ext,0, 2'd1, 2'd2, 2'd0, alu);
    endfunction

    initial begin
        F   = ctl(1,0,1,0,1,0,0,0,0,0, 2'd0, 2'd1, 2'd0, 4'd2);
        FI  = ctl(1,0,1,0,1,0,0,0,0,1, 2'd0, 2'd1, 2'd0, 4'd2);
        D   = ctl(0,0,0,0,0,0,0,0,1,0, 2'd0, 2'd3, 2'd0, 4'd2);
        MA  = ctl(0,0,0,0,0,0,0,0,1,0, 2'd1, 2'd2, 2'd0, 4'd2);
        MRD = ctl(0,1,1,0,0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 4'd0);
        MWB = ctl(0,0,0,0,0,1,0,1,0,0, 2'd0, 2'd0, 2'd0, 4'd0);
        MWR = ctl(0,1,0,1,0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 4'd0);
        RWB = ctl(0,0,0,0,0,0,1,1,0,0, 2'd0, 2'd0, 2'd0, 4'd0);
        JMP = ctl(1,0,0,0,0,0,0,0,0,0, 2'd0, 2'd0, 2'd2, 4'd0);

        add(6'h23, 6'h00, 0, 4'd0,  20'h0, "init");
        add(6'h23, 6'h00, 0, 4'd1,  F,   "lw_fetch");
        add(6'h23, 6'h00, 0, 4'd2,  D,   "lw_decode");
        add(6'h23, 6'h00, 0, 4'd3,  MA,  "lw_memadr");
        add(6'h23, 6'h00, 0, 4'd4,  MRD, "lw_memrd");
        add(6'h23, 6'h00, 0, 4'd5,  MWB, "lw_memwb");
        add(6'h2B, 6'h00, 0, 4'd1,  F,   "sw_fetch");
        add(6'h2B, 6'h00, 0, 4'd2,  D,   "sw_decode");
        add(6'h2B, 6'h00, 0, 4'd3,  MA,  "sw_memadr");
        add(6'h2B, 6'h00, 0, 4'd6,  MWR, "sw_memwr");
        begin
            logic [5:0] fns[4] = '{6'h20, 6'h22, 6'h02, 6'h00};
            logic [3:0] alus[4] = '{4'd2, 4'd6, 4'd4, 4'd3};
            bit         shs[4] = '{0, 0, 1, 1};
            for (int i = 0; i < 4; i++) begin
                add(6'h00, fns[i], 0, 4'd1, F,   "r_fetch");
                add(6'h00, fns[i], 0, 4'd2, D,   "r_decode");
                add(6'h00, fns[i], 0, 4'd7, rx(alus[i], shs[i]), "r_rxec");
                add(6'h00, fns[i], 0, 4'd8, RWB, "r_rwb");
            end
        end
        begin
            logic [5:0] bops[4] = '{6'h04, 6'h04, 6'h05, 6'h05};
            logic       bz[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
            bit         bpc[4]  = '{1, 0, 0, 1};
            for (int i = 0; i < 4; i++) begin
                add(bops[i], 6'h00, bz[i], 4'd1, F, "br_fetch");
                add(bops[i], 6'h00, bz[i], 4'd2, D, "br_decode");
                add(bops[i], 6'h00, bz[i], 4'd9, br(bpc[i]), "br_branch");
            end
        end
        add(6'h02, 6'h00, 0, 4'd1,  F,   "j_fetch");
        add(6'h02, 6'h00, 0, 4'd2,  D,   "j_decode");
        add(6'h02, 6'h00, 0, 4'd10, JMP, "j_jump");
        begin
            logic [5:0] iops[5] = '{6'h0D, 6'h08, 6'h0F, 6'h0C, 6'h0A};
            logic [3:0] ialu[5] = '{4'd1, 4'd2, 4'd5, 4'd0, 4'd7};
            bit         iext[5] = '{0, 1, 0, 0, 1};
            for (int i = 0; i < 5; i++) begin
                add(iops[i], 6'h00, 0, 4'd1,  F, "i_fetch");
                add(iops[i], 6'h00, 0, 4'd2,  D, "i_decode");
                add(iops[i], 6'h00, 0, 4'd11, ix(ialu[i], iext[i], 0), "i_ixec");
                add(iops[i], 6'h00, 0, 4'd12, ix(ialu[i], iext[i], 1), "i_iwb");
            end
        end
        add(6'h3F, 6'h00, 0, 4'd1,  F,   "ill_fetch");
        add(6'h3F, 6'h00, 0, 4'd2,  D,   "ill_decode");
        add(6'h00, 6'h3F, 0, 4'd1,  FI,  "ill_pulse_fetch");
        add(6'h00, 6'h3F, 0, 4'd2,  D,   "badfn_decode");
        add(6'h00, 6'h3F, 0, 4'd7,  rx(4'd2, 0), "badfn_rxec");
        add(6'h03, 6'h00, 0, 4'd1,  FI,  "badfn_pulse_fetch");
        add(6'h03, 6'h00, 0, 4'd2,  D,   "op03_decode");
`ifdef MC_CTRL_JAL_EN
        add(6'h03, 6'h00, 0, 4'd13, ctl(1,0,0,0,0,0,1,1,0,0, 2'd0, 2'd0, 2'd2, 4'd0), "jal");
        add(6'h2B, 6'h00, 0, 4'd1,  F,   "sw2_fetch");
`else
        add(6'h2B, 6'h00, 0, 4'd1,  FI,  "op03_illegal_fetch");
`endif
        add(6'h2B, 6'h00, 0, 4'd2,  D,   "sw2_decode");
        add(6'h2B, 6'h00, 0, 4'd3,  MA,  "sw2_memadr");
        add(6'h2B, 6'h00, 0, 4'd6,  MWR, "sw2_memwr");

        bus.op = 6'h00; bus.funct = 6'h00; bus.Zero = 1'b0;
        #2;
        check("reset_outputs", 4'd0, 20'h0);
        @(posedge clk); #1;
        check("reset_held", 4'd0, 20'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (i > 0) @(negedge clk);
            bus.op = vecs[i].op; bus.funct = vecs[i].funct; bus.Zero = vecs[i].zero;
            #1;
            check(vecs[i].name, vecs[i].st, vecs[i].ctrl);
        end

        // Asynchronous reset while in MEMWR: strobe must drop without a clock edge.
        #2 rst_n = 1'b0;
        #1 check("async_rst_memwr", 4'd0, 20'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_rst_init", 4'd0, 20'h0);
        @(negedge clk); #1;
        check("post_rst_fetch", 4'd1, F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port op, input, 6, instruction[31:26], read from the instruction register.
REQ-004 SHALL have port funct, input, 6, instruction[5:0].
REQ-005 SHALL have port Zero, input, 1, ALU zero flag (A-B==0).
REQ-006 SHALL have ports PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ExtOp, IllegalOp, each output, 1 bit.
REQ-007 SHALL have outputs ALUSrcA[1:0] (0 PC, 1 regA, 2 regB), ALUSrcB[1:0] (0 regB, 1 const 4, 2 ext imm, 3 ext imm<<2) and PCSource[1:0] (0 ALU result, 1 ALUOut, 2 jump target).
REQ-008 SHALL have output ALUcontrol[3:0] with codes AND0 OR1 ADD2 SLL3 SRL4 LUI5 SUB6 SLT7 NOR8 XOR9, and output state[3:0] for debug.

Function
REQ-009 SHALL implement a Moore FSM with states INIT0 FETCH1 DECODE2 MEMADR3 MEMRD4 MEMWB5 MEMWR6 RXEC7 RWB8 BRANCH9 JUMP10 IXEC11 IWB12 (JAL13 when configured); all other encodings go to FETCH.
REQ-010 INIT SHALL drive every output to 0 and go to FETCH on the next cycle.
REQ-011 FETCH SHALL drive MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUcontrol=ADD, PCSource=0 and PCEn=1, then go to DECODE.
REQ-012 DECODE SHALL drive ALUSrcA=0, ALUSrcB=3, ExtOp=1 and ALUcontrol=ADD (branch target into ALUOut), then dispatch on op as follows.
- 0x23 lw, 0x2B sw -> MEMADR
- 0x00 R-type -> RXEC
- 0x04 beq, 0x05 bne -> BRANCH
- 0x02 j -> JUMP
- 0x08/0x0C/0x0D/0x0E/0x0A/0x0F -> IXEC
REQ-013 DECODE with any other op SHALL pulse IllegalOp=1 for one cycle and return to FETCH; no register or memory write occurs.
REQ-014 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=2, ExtOp=1 and ALUcontrol=ADD, then go to MEMRD (lw) or MEMWR (sw).
REQ-015 MEMRD SHALL drive MemRead=1 and IorD=1, then go to MEMWB.
REQ-016 MEMWB SHALL drive RegWrite=1, MemtoReg=1 and RegDst=0, then go to FETCH.
REQ-017 MEMWR SHALL drive MemWrite=1 and IorD=1, then go to FETCH.
REQ-018 RXEC SHALL map funct to ALUcontrol as follows: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x00 SLL, 0x02 SRL.
- sll/srl: ALUSrcA=2, ALUSrcB=2 (shamt sits in imm[10:6])
- all others: ALUSrcA=1, ALUSrcB=0
REQ-019 RXEC with an unknown funct SHALL pulse IllegalOp and go to FETCH; otherwise it SHALL go to RWB.
REQ-020 RWB SHALL drive RegWrite=1, RegDst=1 and MemtoReg=0, then go to FETCH.
REQ-021 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=0, ALUcontrol=SUB and PCSource=1, with PCEn=Zero for beq and PCEn=~Zero for bne (the only Mealy output), then go to FETCH.
REQ-022 JUMP SHALL drive PCSource=2 and PCEn=1, then go to FETCH.
REQ-023 IXEC SHALL drive ALUSrcA=1 and ALUSrcB=2, then go to IWB, with ALUcontrol and ExtOp per op as follows.
- addi: ADD, ExtOp 1
- andi: AND, ExtOp 0
- ori: OR, ExtOp 0
- xori: XOR, ExtOp 0
- slti: SLT, ExtOp 1
- lui: LUI, ExtOp 0
REQ-024 IWB SHALL drive RegWrite=1, RegDst=0 and MemtoReg=0, then go to FETCH; IXEC's ALU settings SHALL be held in IWB.
REQ-025 Per-instruction cycle counts SHALL be: lw 5; sw, R-type and I-type 4; beq, bne and j 3.

Reset
REQ-026 rst_n low SHALL force state=INIT and all outputs to 0 immediately, regardless of clk.
REQ-027 Reset asserted mid-instruction SHALL abandon that instruction with no further write strobe; after release the first edge enters INIT, then FETCH.

Configuration
REQ-028 With MC_CTRL_JAL_EN defined, DECODE SHALL route op 0x03 to JAL.
- JAL drives PCSource=2, PCEn=1, RegWrite=1, the link write of PC+4 to r31 (RegDst=1, MemtoReg=0), then goes to FETCH
- RegDst widening is outside this block's scope, so the datapath decodes r31 from op
REQ-029 Without MC_CTRL_JAL_EN, op 0x03 SHALL be treated as illegal (IllegalOp pulse, return to FETCH).

Structure
REQ-030 A shared package SHALL hold the state encodings, the opcode/funct constants and the ALUcontrol codes; the ALU SHALL use the same codes.
REQ-031 A single sub-module alu_decode SHALL contain the combinational funct/op to ALUcontrol/ExtOp mapping; the FSM stays in the top module.

Verification
REQ-032 Release reset, op=0x23 -> states 0,1,2,3,4,5,1; MemtoReg=1 and RegWrite=1 only in state 5.
REQ-033 op=0x00, funct=0x02 -> RXEC drives ALUcontrol=4, ALUSrcA=2, ALUSrcB=2; RWB drives RegDst=1.
REQ-034 op=0x05, Zero=1 -> PCEn=0 in BRANCH; with Zero=0 -> PCEn=1, PCSource=1.
REQ-035 op=0x0D -> IXEC drives ALUcontrol=1, ExtOp=0; op=0x3F -> IllegalOp=1 for one cycle, then FETCH.
REQ-036 rst_n low during MEMWR -> MemWrite falls to 0 with no clk edge; after release, INIT then FETCH.
REQ-037 op=0x03 with and without MC_CTRL_JAL_EN -> state 13 with RegWrite=1, versus an IllegalOp pulse.
